// File: rtl/flash_page_prog_ctrl.sv
// Multi-page QSPI flash programmer: per 256-byte page issues WREN, 4-byte Page Program
// with 32 FIFO words, then polls RDSR until WIP clears. All outputs are registered.
module flash_page_prog_ctrl #(
  parameter int POLL_MAX    = 65535,
  parameter int WDOG_CYCLES = 1048575
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [15:0] num_pages,
  output logic        done,
  output logic        error,
  output logic        busy,
  input  logic [63:0] buff_data,
  input  logic        buff_empty,
  input  logic        buff_prog_empty,
  output logic        buff_rden,
  output logic        load_out,
  input  logic        load_full_in,
  output logic [7:0]  command_len_out,
  output logic [7:0]  addr_len_out,
  output logic [7:0]  dummy_len_out,
  output logic [15:0] data_len_out,
  output logic [31:0] command_out,
  output logic [63:0] addr_out,
  output logic [63:0] data_out,
  output logic        tristate_out,
  input  logic        spi_busy_in,
  input  logic [63:0] fetch_din,
  output logic        fetch_out,
  input  logic        fetch_empty_in
);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);
  localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_BUF, S_WREN_LD, S_WREN_WT, S_PP_HDR, S_PP_DATA, S_PP_WT,
    S_RS_LD, S_RS_WT, S_RS_FETCH, S_RS_CHK, S_DONE, S_ERR
  } state_t;

  state_t        r_state, w_state;
  logic [31:0]   r_addr, w_addr;
  logic [15:0]   r_pages, w_pages;
  logic [5:0]    r_word, w_word;
  logic [PW-1:0] r_poll, w_poll;
  logic [WW-1:0] r_wdog;
  logic          r_seen, r_wip, w_wip;
  logic          r_done, w_done, r_error, w_error, r_busy;
  logic          r_rden, w_rden, r_load, w_load, r_fetch, w_fetch, r_tri, w_tri;
  logic [7:0]    r_cmd, w_cmd, r_cmd_len, w_cmd_len, r_addr_len, w_addr_len, r_dummy_len, w_dummy_len;
  logic [15:0]   r_data_len, w_data_len;
  logic [31:0]   r_addr_o, w_addr_o;
  logic [63:0]   r_data, w_data;

  // A pop or load is never issued back-to-back: the cycle after one, the FIFO head and
  // the phy full flag still reflect the previous transfer.
  logic w_can_ld, w_can_pop, w_txn_end, w_wdog_exp;
  assign w_can_ld   = !load_full_in && !r_load;
  assign w_can_pop  = w_can_ld && !buff_empty && !r_rden;
  assign w_txn_end  = r_seen && !spi_busy_in;
  assign w_wdog_exp = (r_wdog == WDOG_LIM);

  always_comb begin
    w_state = r_state;   w_addr = r_addr;   w_pages = r_pages;  w_word = r_word;
    w_poll = r_poll;     w_wip = r_wip;     w_error = r_error;
    w_done = 1'b0;       w_rden = 1'b0;     w_load = 1'b0;      w_fetch = 1'b0;
    w_cmd = r_cmd;       w_cmd_len = r_cmd_len;  w_addr_len = r_addr_len;
    w_dummy_len = r_dummy_len;  w_data_len = r_data_len;
    w_addr_o = r_addr_o; w_data = r_data;   w_tri = r_tri;
    case (r_state)
      S_IDLE: if (start) begin
        w_addr  = {start_addr[31:8], 8'h00};
        w_pages = num_pages;
        w_error = 1'b0;
        w_poll  = '0;
        w_state = (num_pages == 16'd0) ? S_DONE : S_WAIT_BUF;
      end
      S_WAIT_BUF: if (!buff_prog_empty) w_state = S_WREN_LD;
      S_WREN_LD: if (w_can_ld) begin
        w_load = 1'b1; w_cmd = 8'h06; w_cmd_len = 8'd8; w_addr_len = 8'd0;
        w_dummy_len = 8'd0; w_data_len = 16'd0; w_tri = 1'b0;
        w_state = S_WREN_WT;
      end
      S_WREN_WT:
        if (w_txn_end)       w_state = S_PP_HDR;
        else if (w_wdog_exp) w_state = S_ERR;
      S_PP_HDR: if (w_can_pop) begin
        w_load = 1'b1; w_rden = 1'b1; w_cmd = 8'h12; w_cmd_len = 8'd8; w_addr_len = 8'd32;
        w_dummy_len = 8'd0; w_data_len = 16'd2048; w_tri = 1'b0;
        w_addr_o = r_addr; w_data = buff_data; w_word = 6'd1;
        w_state = S_PP_DATA;
      end
      S_PP_DATA: if (w_can_pop) begin
        w_load = 1'b1; w_rden = 1'b1; w_data = buff_data; w_word = r_word + 6'd1;
        if (r_word == 6'd31) w_state = S_PP_WT;
      end
      S_PP_WT:
        if (w_txn_end)       w_state = S_RS_LD;
        else if (w_wdog_exp) w_state = S_ERR;
      S_RS_LD: if (w_can_ld) begin
        w_load = 1'b1; w_cmd = 8'h05; w_cmd_len = 8'd8; w_addr_len = 8'd0;
        w_dummy_len = 8'd0; w_data_len = 16'd8; w_tri = 1'b1;
        w_poll = r_poll + 1'b1;
        w_state = S_RS_WT;
      end
      S_RS_WT:
        if (w_txn_end && !fetch_empty_in) w_state = S_RS_FETCH;
        else if (w_wdog_exp)              w_state = S_ERR;
      // Status byte is the FWFT head here; latch WIP while popping it.
      S_RS_FETCH: begin
        w_fetch = 1'b1; w_wip = fetch_din[0]; w_state = S_RS_CHK;
      end
      S_RS_CHK:
        if (r_wip) w_state = (r_poll == POLL_LIM) ? S_ERR : S_RS_LD;
        else begin
          w_addr  = r_addr + 32'd256;
          w_pages = r_pages - 16'd1;
          w_poll  = '0;
          w_state = (r_pages == 16'd1) ? S_DONE : S_WAIT_BUF;
        end
      S_DONE: begin w_done = 1'b1; w_state = S_IDLE; end
      S_ERR:  begin w_error = 1'b1; w_state = S_IDLE; end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE; r_addr <= '0; r_pages <= '0; r_word <= '0; r_poll <= '0;
      r_wdog <= '0; r_seen <= 1'b0; r_wip <= 1'b0;
      r_done <= 1'b0; r_error <= 1'b0; r_busy <= 1'b0; r_rden <= 1'b0; r_load <= 1'b0;
      r_fetch <= 1'b0; r_tri <= 1'b0; r_cmd <= '0; r_cmd_len <= '0; r_addr_len <= '0;
      r_dummy_len <= '0; r_data_len <= '0; r_addr_o <= '0; r_data <= '0;
    end else begin
      r_state <= w_state; r_addr <= w_addr; r_pages <= w_pages; r_word <= w_word;
      r_poll <= w_poll; r_wip <= w_wip;
      r_done <= w_done; r_error <= w_error; r_busy <= (w_state != S_IDLE);
      r_rden <= w_rden; r_load <= w_load; r_fetch <= w_fetch; r_tri <= w_tri;
      r_cmd <= w_cmd; r_cmd_len <= w_cmd_len; r_addr_len <= w_addr_len;
      r_dummy_len <= w_dummy_len; r_data_len <= w_data_len; r_addr_o <= w_addr_o; r_data <= w_data;
      // Busy-seen flag and watchdog both restart on every state entry.
      if (w_state != r_state) begin
        r_seen <= 1'b0;
        r_wdog <= '0;
      end else begin
        if (spi_busy_in) r_seen <= 1'b1;
        if (r_state == S_WREN_WT || r_state == S_PP_WT || r_state == S_RS_WT)
          r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign done            = r_done;
  assign error           = r_error;
  assign busy            = r_busy;
  assign buff_rden       = r_rden;
  assign load_out        = r_load;
  assign fetch_out       = r_fetch;
  assign tristate_out    = r_tri;
  assign command_len_out = r_cmd_len;
  assign addr_len_out    = r_addr_len;
  assign dummy_len_out   = r_dummy_len;
  assign data_len_out    = r_data_len;
  assign command_out     = {24'h0, r_cmd};
  assign addr_out        = {32'h0, r_addr_o};
  assign data_out        = r_data;
endmodule

// File: tb/tb_flash_page_prog_ctrl.sv
// Bench for flash_page_prog_ctrl: FIFO/phy models, expected load stream built per page.
module tb_flash_page_prog_ctrl;
  localparam int POLL_MAX = 4;
  localparam int WDOG     = 200;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] num_pages = '0;
  logic done, error, busy, buff_rden, load_out, tristate_out, fetch_out;
  logic [63:0] buff_data = '0;
  logic buff_empty = 1'b1, buff_prog_empty = 1'b1, load_full_in = 1'b0;
  logic spi_busy_in = 1'b0, fetch_empty_in = 1'b1;
  logic [63:0] fetch_din = '0;
  logic [7:0] command_len_out, addr_len_out, dummy_len_out;
  logic [15:0] data_len_out;
  logic [31:0] command_out;
  logic [63:0] addr_out, data_out;

  always #5 clk = ~clk;

  flash_page_prog_ctrl #(.POLL_MAX(POLL_MAX), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_pages(num_pages),
    .done(done), .error(error), .busy(busy), .buff_data(buff_data), .buff_empty(buff_empty),
    .buff_prog_empty(buff_prog_empty), .buff_rden(buff_rden), .load_out(load_out),
    .load_full_in(load_full_in), .command_len_out(command_len_out), .addr_len_out(addr_len_out),
    .dummy_len_out(dummy_len_out), .data_len_out(data_len_out), .command_out(command_out),
    .addr_out(addr_out), .data_out(data_out), .tristate_out(tristate_out),
    .spi_busy_in(spi_busy_in), .fetch_din(fetch_din), .fetch_out(fetch_out),
    .fetch_empty_in(fetch_empty_in));

  typedef struct {
    logic [31:0] cmd; logic [63:0] addr; logic [63:0] data;
    logic [7:0] cl, al, dl; logic [15:0] dal; logic tri_s;
  } ld_t;

  ld_t log_q[$], exp_q[$];
  logic [63:0] buf_q[$], exp_words[$];
  logic [7:0] fq[$];
  bit wip_q[$];
  int exp_polls[$];
  int tests = 0, fails = 0, proto_err = 0, pop_cnt = 0, done_cnt = 0, pp_cnt = 0, busy_cnt = 0;
  bit full_toggle = 0, force_empty = 0, hang = 0, wip_stuck = 0, txn_rd = 0, full_s = 0, empty_s = 1;

  always @(posedge clk) begin full_s = load_full_in; empty_s = buff_empty; end

  // FIFO, phy and status-register models; all updates happen on the falling edge.
  always @(negedge clk) begin
    logic [63:0] t64; logic [7:0] t8; logic [6:0] r7; bit w;
    if (rst) begin
      busy_cnt = 0; pp_cnt = 0; fq.delete(); txn_rd = 0; spi_busy_in = 1'b0;
    end else begin
      if (load_out && full_s) proto_err++;
      if (buff_rden && empty_s) proto_err++;
      if (buff_rden) begin
        pop_cnt++;
        if (buf_q.size() == 0) proto_err++; else t64 = buf_q.pop_front();
      end
      if (fetch_out) begin
        if (fq.size() == 0) proto_err++; else t8 = fq.pop_front();
      end
      if (done) done_cnt++;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0 && txn_rd) begin
          w = wip_stuck ? 1'b1 : (wip_q.size() > 0 ? wip_q.pop_front() : 1'b0);
          r7 = 7'($urandom);
          fq.push_back({r7, w});
        end
      end
      if (load_out) begin
        ld_t e;
        e.cmd = command_out; e.addr = addr_out; e.data = data_out; e.cl = command_len_out;
        e.al = addr_len_out; e.dl = dummy_len_out; e.dal = data_len_out; e.tri_s = tristate_out;
        log_q.push_back(e);
        if (!hang) begin
          if (command_out == 32'h12) begin
            pp_cnt++;
            if (pp_cnt == 32) begin pp_cnt = 0; busy_cnt = $urandom_range(3, 6); txn_rd = 0; end
          end else begin
            busy_cnt = $urandom_range(3, 6); txn_rd = (command_out == 32'h05);
          end
        end
      end
      spi_busy_in = (busy_cnt > 0);
    end
    load_full_in    = (full_toggle && !rst) ? ~load_full_in : 1'b0;
    buff_empty      = force_empty || (buf_q.size() == 0);
    buff_data       = (buf_q.size() > 0) ? buf_q[0] : 64'h0;
    buff_prog_empty = (buf_q.size() < 32);
    fetch_empty_in  = (fq.size() == 0);
    fetch_din       = (fq.size() > 0) ? {56'h0, fq[0]} : 64'h0;
  end

  // Loads numbered page-wise: WREN, 32 PP words at the page address, then one RDSR per poll.
  task automatic build_exp(input logic [31:0] base);
    ld_t e; int w; logic [31:0] pa;
    w = 0; exp_q.delete();
    for (int p = 0; p < exp_polls.size(); p++) begin
      pa = {base[31:8], 8'h00} + 32'(p * 256);
      e.cmd = 32'h06; e.addr = '0; e.data = '0; e.cl = 8; e.al = 0; e.dl = 0; e.dal = 0; e.tri_s = 0;
      exp_q.push_back(e);
      for (int i = 0; i < 32; i++) begin
        e.cmd = 32'h12; e.addr = {32'h0, pa}; e.data = exp_words[w]; w++;
        e.al = 32; e.dal = 2048; e.tri_s = 0;
        exp_q.push_back(e);
      end
      for (int i = 0; i < exp_polls[p]; i++) begin
        e.cmd = 32'h05; e.addr = '0; e.data = '0; e.al = 0; e.dal = 8; e.tri_s = 1;
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic int log_diff();
    if (log_q.size() != exp_q.size()) return -2;
    foreach (log_q[i]) begin
      if (log_q[i].cmd !== exp_q[i].cmd || log_q[i].cl !== exp_q[i].cl || log_q[i].al !== exp_q[i].al ||
          log_q[i].dl !== exp_q[i].dl || log_q[i].dal !== exp_q[i].dal || log_q[i].tri_s !== exp_q[i].tri_s)
        return i;
      if (exp_q[i].cmd == 32'h12 && (log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data))
        return i;
    end
    return -1;
  endfunction

  task automatic push_words(input int n);
    logic [63:0] v;
    for (int i = 0; i < n; i++) begin
      v = {$urandom, $urandom};
      buf_q.push_back(v); exp_words.push_back(v);
    end
  endtask

  task automatic set_polls(input int k);
    exp_polls.push_back(k + 1);
    for (int i = 0; i < k; i++) wip_q.push_back(1'b1);
    wip_q.push_back(1'b0);
  endtask

  task automatic clear_model();
    exp_words.delete(); exp_polls.delete(); wip_q.delete();
  endtask

  task automatic start_op(input logic [31:0] a, input logic [15:0] n);
    log_q.delete(); pop_cnt = 0; done_cnt = 0; proto_err = 0;
    @(negedge clk); start_addr = a; num_pages = n; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(output bit tmo);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && error !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
    tmo = (cyc >= 20000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    tests++; if ({done, error, busy, buff_rden, load_out, fetch_out, tristate_out} !== 7'b0) begin
      fails++; $display("FAIL reset_ctl: got %b want 0", {done, error, busy, buff_rden, load_out, fetch_out, tristate_out}); end
    tests++; if ({command_out, addr_out, data_out} !== 160'b0) begin
      fails++; $display("FAIL reset_desc: got %h %h %h want 0", command_out, addr_out, data_out); end
    tests++; if ({command_len_out, addr_len_out, dummy_len_out, data_len_out} !== 40'b0) begin
      fails++; $display("FAIL reset_len: got %h want 0", {command_len_out, addr_len_out, dummy_len_out, data_len_out}); end
  endtask

  task automatic test_single_page();
    bit tmo; int d;
    clear_model(); push_words(32); set_polls(2);
    start_op(32'h0001_23AB, 16'd1); wait_end(tmo); build_exp(32'h0001_23AB); d = log_diff();
    tests++; if (tmo) begin fails++; $display("FAIL single_tmo: got timeout want done"); end
    tests++; if (d !== -1) begin fails++; $display("FAIL single_log: got diff at %0d (n=%0d) want none", d, log_q.size()); end
    tests++; if (log_q.size() !== 36) begin fails++; $display("FAIL single_nload: got %0d want 36", log_q.size()); end
    tests++; if (pop_cnt !== 32) begin fails++; $display("FAIL single_pops: got %0d want 32", pop_cnt); end
    tests++; if (done_cnt !== 1 || error !== 1'b0) begin fails++; $display("FAIL single_done: got done=%0d err=%b want 1 0", done_cnt, error); end
    tests++; if (proto_err !== 0) begin fails++; $display("FAIL single_proto: got %0d want 0", proto_err); end
  endtask

  task automatic test_multi_page();
    bit tmo; int d;
    clear_model(); push_words(96);
    for (int p = 0; p < 3; p++) set_polls($urandom_range(0, 2));
    start_op(32'hFFFF_FF00, 16'd3); wait_end(tmo); build_exp(32'hFFFF_FF00); d = log_diff();
    tests++; if (tmo) begin fails++; $display("FAIL multi_tmo: got timeout want done"); end
    tests++; if (d !== -1) begin fails++; $display("FAIL multi_log: got diff at %0d (n=%0d) want none", d, log_q.size()); end
    tests++; if (pop_cnt !== 96) begin fails++; $display("FAIL multi_pops: got %0d want 96", pop_cnt); end
    tests++; if (done_cnt !== 1 || error !== 1'b0) begin fails++; $display("FAIL multi_done: got done=%0d err=%b want 1 0", done_cnt, error); end
    tests++; if (proto_err !== 0) begin fails++; $display("FAIL multi_proto: got %0d want 0", proto_err); end
  endtask

  task automatic test_wait_buf();
    bit tmo; int d; logic [31:0] a;
    a = $urandom;
    clear_model(); push_words(31); set_polls($urandom_range(0, 2));
    start_op(a, 16'd1);
    repeat (20) @(negedge clk);
    tests++; if (log_q.size() !== 0) begin fails++; $display("FAIL waitbuf_noload: got %0d loads want 0", log_q.size()); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL waitbuf_busy: got %b want 1", busy); end
    push_words(1);
    wait_end(tmo); build_exp(a); d = log_diff();
    tests++; if (tmo || done_cnt !== 1) begin fails++; $display("FAIL waitbuf_done: got tmo=%b done=%0d want 0 1", tmo, done_cnt); end
    tests++; if (d !== -1) begin fails++; $display("FAIL waitbuf_log: got diff at %0d want none", d); end
  endtask

  task automatic test_stall();
    bit tmo; int d, cyc, p0; logic [31:0] a;
    a = $urandom;
    clear_model(); push_words(32); set_polls($urandom_range(0, 2));
    full_toggle = 1;
    start_op(a, 16'd1);
    cyc = 0;
    while (pop_cnt < 10 && cyc < 2000) begin @(negedge clk); cyc++; end
    tests++; if (cyc >= 2000) begin fails++; $display("FAIL stall_reach10: got %0d pops want 10", pop_cnt); end
    force_empty = 1; @(negedge clk); p0 = pop_cnt;
    repeat (9) @(negedge clk);
    tests++; if (pop_cnt - p0 > 1) begin fails++; $display("FAIL stall_empty_pops: got %0d want <=1", pop_cnt - p0); end
    force_empty = 0;
    wait_end(tmo); full_toggle = 0; build_exp(a); d = log_diff();
    tests++; if (tmo || done_cnt !== 1) begin fails++; $display("FAIL stall_done: got tmo=%b done=%0d want 0 1", tmo, done_cnt); end
    tests++; if (d !== -1) begin fails++; $display("FAIL stall_log: got diff at %0d want none", d); end
    tests++; if (pop_cnt !== 32) begin fails++; $display("FAIL stall_pops: got %0d want 32", pop_cnt); end
    tests++; if (proto_err !== 0) begin fails++; $display("FAIL stall_proto: got %0d want 0", proto_err); end
  endtask

  task automatic test_poll_err();
    bit tmo; int d;
    clear_model(); push_words(32); exp_polls.push_back(POLL_MAX);
    wip_stuck = 1;
    start_op(32'h0000_4000, 16'd1); wait_end(tmo); wip_stuck = 0;
    build_exp(32'h0000_4000); d = log_diff();
    tests++; if (error !== 1'b1 || tmo) begin fails++; $display("FAIL pollerr_err: got err=%b tmo=%b want 1 0", error, tmo); end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL pollerr_nodone: got %0d want 0", done_cnt); end
    tests++; if (d !== -1) begin fails++; $display("FAIL pollerr_log: got diff at %0d (n=%0d) want none", d, log_q.size()); end
    start_op(32'h0, 16'd0); wait_end(tmo);
    tests++; if (error !== 1'b0 || done_cnt !== 1) begin fails++; $display("FAIL pollerr_clear: got err=%b done=%0d want 0 1", error, done_cnt); end
  endtask

  task automatic test_watchdog();
    bit tmo;
    clear_model(); push_words(32);
    hang = 1;
    start_op(32'h0000_8000, 16'd1); wait_end(tmo); hang = 0;
    tests++; if (error !== 1'b1 || tmo) begin fails++; $display("FAIL wdog_err: got err=%b tmo=%b want 1 0", error, tmo); end
    tests++; if (log_q.size() !== 1) begin fails++; $display("FAIL wdog_nload: got %0d want 1", log_q.size()); end
    else begin
      tests++; if (log_q[0].cmd !== 32'h06) begin fails++; $display("FAIL wdog_cmd: got %h want 06", log_q[0].cmd); end
    end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL wdog_nodone: got %0d want 0", done_cnt); end
    buf_q.delete();
  endtask

  task automatic test_reset_mid();
    int cyc, n0, p0;
    clear_model(); push_words(32); set_polls(0);
    start_op($urandom, 16'd1);
    cyc = 0;
    while (pop_cnt < 10 && cyc < 2000) begin @(negedge clk); cyc++; end
    rst = 1'b1; @(negedge clk);
    tests++; if ({done, error, busy, buff_rden, load_out, fetch_out, tristate_out} !== 7'b0) begin
      fails++; $display("FAIL rstmid_ctl: got %b want 0", {done, error, busy, buff_rden, load_out, fetch_out, tristate_out}); end
    tests++; if ({command_out, addr_out, data_out, command_len_out, addr_len_out, dummy_len_out, data_len_out} !== 200'b0) begin
      fails++; $display("FAIL rstmid_desc: got %h %h want 0", command_out, addr_out); end
    rst = 1'b0; n0 = log_q.size(); p0 = pop_cnt;
    repeat (10) @(negedge clk);
    tests++; if (log_q.size() !== n0 || pop_cnt !== p0) begin
      fails++; $display("FAIL rstmid_quiet: got loads+%0d pops+%0d want 0 0", log_q.size() - n0, pop_cnt - p0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got busy=%b want 0", busy); end
    buf_q.delete(); wip_q.delete();
  endtask

  task automatic test_zero_pages();
    start_op($urandom, 16'd0);
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zero_c1: got busy=%b done=%b want 1 0", busy, done); end
    @(negedge clk);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL zero_c2: got done=%b busy=%b want 1 0", done, busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_c3: got done=%b want 0", done); end
    tests++; if (log_q.size() !== 0) begin fails++; $display("FAIL zero_noload: got %0d want 0", log_q.size()); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_single_page();
    test_multi_page();
    test_wait_buf();
    test_stall();
    test_poll_err();
    test_watchdog();
    test_reset_mid();
    test_zero_pages();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
